// File: rtl/systolic_pkg.sv
// Shared constants and types for the 3x3 systolic array controller.
package systolic_pkg;

    localparam int N             = 3;
    localparam int DW            = 8;
    localparam int CW            = 16;
    localparam int CLR_CYC_DEF   = 2;
    localparam int DRAIN_CYC_DEF = 4;
    localparam int FEED_CYC      = 2 * N - 1;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One matrix row, element m in bits [8m+7:8m].
    typedef logic [N-1:0][DW-1:0] row_t;
    // Full matrix, indexed [row][column].
    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

endpackage

// File: rtl/systolic_feed.sv
// Skew generator: row i of A enters i cycles late, column j of B enters j cycles late.
module systolic_feed
    import systolic_pkg::*;
(
    input  logic                 feedEn_i,
    input  logic [2:0]           t_i,
    input  mat_t                 aMat_i,
    input  mat_t                 bMat_i,
    output logic signed [DW-1:0] a0_o,
    output logic signed [DW-1:0] a1_o,
    output logic signed [DW-1:0] a2_o,
    output logic signed [DW-1:0] b0_o,
    output logic signed [DW-1:0] b1_o,
    output logic signed [DW-1:0] b2_o
);

    row_t aFeed;
    row_t bFeed;

    // Pick the diagonal element for each lane, or zero outside its window.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            aFeed[i] = '0;
            bFeed[i] = '0;
            if (feedEn_i && (t_i >= 3'(i)) && ((t_i - 3'(i)) <= 3'(N - 1))) begin
                aFeed[i] = aMat_i[i][2'(t_i - 3'(i))];
                bFeed[i] = bMat_i[2'(t_i - 3'(i))][i];
            end
        end
    end

    assign a0_o = aFeed[0];
    assign a1_o = aFeed[1];
    assign a2_o = aFeed[2];
    assign b0_o = bFeed[0];
    assign b1_o = bFeed[1];
    assign b2_o = bFeed[2];

endmodule

// File: rtl/systolic_ctrl.sv
// Controller for a 3x3 systolic multiplier: loads A/B, clears the array,
// feeds skewed operands, waits for the pipeline to drain and captures C.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int CLR_CYC   = CLR_CYC_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      in_a_row,
    input  logic [N*DW-1:0]      in_b_row,
    output logic                 pe_rst_n,
    output logic signed [DW-1:0] a0,
    output logic signed [DW-1:0] a1,
    output logic signed [DW-1:0] a2,
    output logic signed [DW-1:0] b0,
    output logic signed [DW-1:0] b1,
    output logic signed [DW-1:0] b2,
    input  logic [N*N*CW-1:0]    c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*CW-1:0]    out_c,
    output logic                 busy
);

    localparam int              CNT_W      = 8;
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    state_e                state_q,   state_d;
    logic [1:0]            beatCnt_q, beatCnt_d;
    logic [CNT_W-1:0]      cycCnt_q,  cycCnt_d;
    mat_t                  aMat_q,    aMat_d;
    mat_t                  bMat_q,    bMat_d;
    logic [N*N*CW-1:0]     outC_q,    outC_d;
    logic                  rstSeen_q;

    // Next-state logic: beat counting in LOAD, phase counting afterwards.
    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        cycCnt_d  = cycCnt_q;
        aMat_d    = aMat_q;
        bMat_d    = bMat_q;
        outC_d    = outC_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    aMat_d[beatCnt_q] = in_a_row;
                    bMat_d[beatCnt_q] = in_b_row;
                    if (beatCnt_q == 2'(N - 1)) begin
                        beatCnt_d = '0;
                        cycCnt_d  = '0;
                        state_d   = ST_CLEAR;
                    end else begin
                        beatCnt_d = beatCnt_q + 2'd1;
                    end
                end
            end
            ST_CLEAR: begin
                cycCnt_d = cycCnt_q + 1'b1;
                if (cycCnt_q == CLR_LAST) begin
                    cycCnt_d = '0;
                    state_d  = ST_FEED;
                end
            end
            ST_FEED: begin
                cycCnt_d = cycCnt_q + 1'b1;
                if (cycCnt_q == FEED_LAST) begin
                    cycCnt_d = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cycCnt_d = cycCnt_q + 1'b1;
                if (cycCnt_q == DRAIN_LAST) begin
                    cycCnt_d = '0;
                    outC_d   = c_in;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State registers; reset discards any partial load and the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            beatCnt_q <= '0;
            cycCnt_q  <= '0;
            aMat_q    <= '0;
            bMat_q    <= '0;
            outC_q    <= '0;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
            cycCnt_q  <= cycCnt_d;
            aMat_q    <= aMat_d;
            bMat_q    <= bMat_d;
            outC_q    <= outC_d;
        end
    end

    // Remembers that reset was sampled so the array stays cleared for that cycle.
    always_ff @(posedge clk) begin
        rstSeen_q <= rst;
    end

    systolic_feed uFeed (
        .feedEn_i (state_q == ST_FEED),
        .t_i      (cycCnt_q[2:0]),
        .aMat_i   (aMat_q),
        .bMat_i   (bMat_q),
        .a0_o     (a0),
        .a1_o     (a1),
        .a2_o     (a2),
        .b0_o     (b0),
        .b1_o     (b1),
        .b2_o     (b2)
    );

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign out_valid = (state_q == ST_DONE);
    assign pe_rst_n  = !rstSeen_q && (state_q != ST_CLEAR);
    assign out_c     = outC_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: drives a behavioural 3x3 PE array from the
// controller's feeds and compares results against a plain matrix product.
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int CLR   = 2;
    localparam int DRAIN = 4;
    localparam int LAT   = CLR + 5 + DRAIN;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [23:0]        in_a_row;
    logic [23:0]        in_b_row;
    logic               pe_rst_n;
    logic signed [7:0]  a0, a1, a2, b0, b1, b2;
    logic [143:0]       c_in;
    logic               out_valid;
    logic               out_ready;
    logic [143:0]       out_c;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic signed [7:0]  mA [3][3];
    logic signed [7:0]  mB [3][3];
    logic [143:0]       expC;

    always #5 clk = ~clk;

    systolic_ctrl #(.CLR_CYC(CLR), .DRAIN_CYC(DRAIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_row  (in_a_row),
        .in_b_row  (in_b_row),
        .pe_rst_n  (pe_rst_n),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
    );

    // Behavioural PE array: a moves right, b moves down, each PE accumulates.
    logic signed [7:0] aF [3];
    logic signed [7:0] bF [3];
    logic signed [7:0] aReg [3][3];
    logic signed [7:0] bReg [3][3];
    logic [15:0]       acc [3][3];

    assign aF[0] = a0;
    assign aF[1] = a1;
    assign aF[2] = a2;
    assign bF[0] = b0;
    assign bF[1] = b1;
    assign bF[2] = b2;

    function automatic logic signed [7:0] aAt(int i, int j);
        if (j == 0) return aF[i];
        return aReg[i][j-1];
    endfunction

    function automatic logic signed [7:0] bAt(int i, int j);
        if (i == 0) return bF[j];
        return bReg[i-1][j];
    endfunction

    function automatic logic [15:0] peProd(int i, int j);
        logic signed [15:0] p;
        p = aAt(i, j) * bAt(i, j);
        return p;
    endfunction

    // Array register update on every rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!pe_rst_n) begin
                    aReg[i][j] <= '0;
                    bReg[i][j] <= '0;
                    acc[i][j]  <= '0;
                end else begin
                    aReg[i][j] <= aAt(i, j);
                    bReg[i][j] <= bAt(i, j);
                    acc[i][j]  <= acc[i][j] + peProd(i, j);
                end
            end
        end
    end

    // Pack the array accumulators onto the result bus.
    always_comb begin
        c_in = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                c_in[16*(3*i+j) +: 16] = acc[i][j];
    end

    // Reference: plain matrix product truncated to 16 bits.
    function automatic logic [143:0] refMul();
        logic [143:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(mA[i][k]) * int'(mB[k][j]);
                r[16*(3*i+j) +: 16] = s[15:0];
            end
        end
        return r;
    endfunction

    // Reference feed values at FEED step t, straight from the skew rule.
    function automatic logic [47:0] feedRef(int t);
        logic signed [7:0] av [3];
        logic signed [7:0] bv [3];
        for (int i = 0; i < 3; i++) begin
            av[i] = '0;
            bv[i] = '0;
            if (t - i >= 0 && t - i <= 2) begin
                av[i] = mA[i][t-i];
                bv[i] = mB[t-i][i];
            end
        end
        return {av[0], av[1], av[2], bv[0], bv[1], bv[2]};
    endfunction

    function automatic logic [23:0] rowOf(bit isB, int k);
        logic [23:0] r;
        for (int m = 0; m < 3; m++)
            r[8*m +: 8] = isB ? mB[k][m] : mA[k][m];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stepCycle();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_pe_rst_n", pe_rst_n, 0);
        checkOutput("rst_feeds", {a0, a1, a2, b0, b1, b2}, 0);
        checkOutput("rst_out_c", out_c, 0);
        rst = 1'b0;
        stepCycle();
        checkOutput("post_rst_pe_rst_n", pe_rst_n, 1);
    endtask

    // Offer the three load beats with random idle gaps; ends on the cycle after beat 2.
    task automatic applyStimulus(input int maxGap);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, maxGap)) begin
                in_valid = 1'b0;
                in_a_row = $urandom;
                in_b_row = $urandom;
                stepCycle();
            end
            in_valid = 1'b1;
            in_a_row = rowOf(1'b0, k);
            in_b_row = rowOf(1'b1, k);
            checkOutput("load_in_ready", in_ready, 1);
            stepCycle();
        end
        in_valid = 1'b0;
        expC = refMul();
    endtask

    // Follow the operation to DONE, checking clear/feed trace and latency.
    task automatic runToDone();
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 60) begin
            if (out_valid) begin
                done = 1'b1;
            end else begin
                checkOutput("busy", busy, 1);
                checkOutput("pe_rst_n_trace", pe_rst_n, (cnt < CLR) ? 1'b0 : 1'b1);
                checkOutput("feed_trace", {a0, a1, a2, b0, b1, b2},
                            (cnt >= CLR && cnt < CLR + 5) ? feedRef(cnt - CLR) : 48'd0);
                in_valid = 1'($urandom);
                in_a_row = $urandom;
                in_b_row = $urandom;
                stepCycle();
                cnt++;
            end
        end
        in_valid = 1'b0;
        checkOutput("latency", cnt, LAT);
        checkOutput("out_c", out_c, expC);
    endtask

    // Stall in DONE for holdCycles with in_valid asserted, then hand off.
    task automatic finishOp(input int holdCycles);
        out_ready = 1'b0;
        for (int h = 0; h < holdCycles; h++) begin
            in_valid = 1'b1;
            in_a_row = $urandom;
            in_b_row = $urandom;
            stepCycle();
        end
        if (holdCycles > 0) begin
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_out_c", out_c, expC);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        checkOutput("done_out_valid", out_valid, 0);
        checkOutput("done_in_ready", in_ready, 1);
        checkOutput("kept_out_c", out_c, expC);
    endtask

    task automatic randomMats();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mA[i][j] = 8'($urandom);
                mB[i][j] = 8'($urandom);
            end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a_row  = '0;
        in_b_row  = '0;
        @(negedge clk);
        doReset();

        $display("[TB] counting matrix product");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mA[i][j] = 8'(3*i + j + 1);
                mB[i][j] = 8'(3*i + j + 1);
            end
        applyStimulus(0);
        checkOutput("ref_known", expC,
                    {16'd150, 16'd126, 16'd102, 16'd96, 16'd81, 16'd66, 16'd42, 16'd36, 16'd30});
        runToDone();
        finishOp(20);

        $display("[TB] identity times B");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mA[i][j] = (i == j) ? 8'sd1 : 8'sd0;
                mB[i][j] = 8'(3*i + j + 1);
            end
        applyStimulus(3);
        runToDone();
        finishOp(0);

        $display("[TB] reset during feed");
        randomMats();
        applyStimulus(0);
        repeat (CLR + 2) stepCycle();
        checkOutput("pre_abort_busy", busy, 1);
        rst = 1'b1;
        stepCycle();
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_pe_rst_n", pe_rst_n, 0);
        checkOutput("abort_feeds", {a0, a1, a2, b0, b1, b2}, 0);
        rst = 1'b0;
        stepCycle();
        randomMats();
        applyStimulus(1);
        runToDone();
        finishOp(1);

        $display("[TB] partial load then reset");
        randomMats();
        in_valid = 1'b1;
        in_a_row = $urandom;
        in_b_row = $urandom;
        stepCycle();
        in_valid = 1'b0;
        doReset();
        applyStimulus(2);
        runToDone();
        finishOp(0);

        $display("[TB] wrap case and random back-to-back operations");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mA[i][j] = -8'sd128;
                mB[i][j] = -8'sd128;
            end
        applyStimulus(0);
        runToDone();
        checkOutput("wrap_elem", out_c[15:0], 16'hC000);
        finishOp(0);
        for (int n = 0; n < 6; n++) begin
            randomMats();
            applyStimulus(3);
            runToDone();
            finishOp($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
